// File: rtl/fpnew_req_sharer.sv
// Shares one FPnew operation-group unit between NumReq requesters: round-robin
// issue with grant locking, outstanding-operation limiting and id-routed responses.
module fpnew_req_sharer #(
  parameter int unsigned NumReq         = 4,
  parameter int unsigned PayloadWidth   = 128,
  parameter int unsigned ResultWidth    = 38,
  parameter int unsigned MaxOutstanding = 4,
  localparam int unsigned IdxWidth      = (NumReq > 1) ? $clog2(NumReq) : 1,
  localparam int unsigned CntWidth      = $clog2(MaxOutstanding + 1)
) (
  input  logic                                 clk_i,
  input  logic                                 rst_ni,
  input  logic                                 flush_i,
  input  logic [NumReq-1:0]                    req_valid_i,
  output logic [NumReq-1:0]                    req_ready_o,
  input  logic [NumReq-1:0][PayloadWidth-1:0]  req_data_i,
  output logic                                 unit_valid_o,
  input  logic                                 unit_ready_i,
  output logic [PayloadWidth-1:0]              unit_data_o,
  output logic [IdxWidth-1:0]                  unit_id_o,
  input  logic                                 unit_out_valid_i,
  output logic                                 unit_out_ready_o,
  input  logic [ResultWidth-1:0]               unit_result_i,
  input  logic [IdxWidth-1:0]                  unit_id_i,
  output logic [NumReq-1:0]                    rsp_valid_o,
  input  logic [NumReq-1:0]                    rsp_ready_i,
  output logic [ResultWidth-1:0]               rsp_data_o,
  output logic                                 busy_o
);

  logic [IdxWidth-1:0] rr_ptr_q, lock_idx_q, arb_idx, grant_idx;
  logic [CntWidth-1:0] count_q;
  logic                locked_q;
  logic                any_req, issue_ok, issue_hs, rsp_hs, out_en;

  // Handshakes are suppressed while reset is asserted as well as during a flush,
  // so a requester holding valid through reset never sees a spurious issue.
  assign out_en  = rst_ni & ~flush_i;
  assign any_req = |req_valid_i;

  always_comb begin : arbiter
    int unsigned cand;
    logic        found;
    arb_idx = '0;
    found   = 1'b0;
    cand    = 0;
    for (int unsigned k = 0; k < NumReq; k++) begin
      cand = (32'(rr_ptr_q) + k) % NumReq;
      if (!found && req_valid_i[cand[IdxWidth-1:0]]) begin
        found   = 1'b1;
        arb_idx = cand[IdxWidth-1:0];
      end
    end
  end

  assign grant_idx    = locked_q ? lock_idx_q : arb_idx;
  assign issue_ok     = (count_q < CntWidth'(MaxOutstanding)) | rsp_hs;
  assign unit_valid_o = (any_req | locked_q) & issue_ok & out_en;
  assign unit_data_o  = req_data_i[grant_idx];
  assign unit_id_o    = grant_idx;
  assign issue_hs     = unit_valid_o & unit_ready_i;

  always_comb begin
    req_ready_o = '0;
    for (int unsigned i = 0; i < NumReq; i++) begin
      req_ready_o[i] = unit_valid_o & unit_ready_i & (32'(grant_idx) == i);
    end
  end

  // An out-of-range result tag matches no requester: it is accepted and dropped.
  always_comb begin
    rsp_valid_o      = '0;
    unit_out_ready_o = 1'b1;
    for (int unsigned i = 0; i < NumReq; i++) begin
      if (32'(unit_id_i) == i) begin
        rsp_valid_o[i]   = unit_out_valid_i & out_en;
        unit_out_ready_o = rsp_ready_i[i];
      end
    end
  end

  assign rsp_data_o = unit_result_i;
  assign rsp_hs     = unit_out_valid_i & unit_out_ready_o;
  assign busy_o     = (count_q != '0) | any_req | locked_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rr_ptr_q   <= '0;
      lock_idx_q <= '0;
      locked_q   <= 1'b0;
      count_q    <= '0;
    end else if (flush_i) begin
      locked_q <= 1'b0;
      count_q  <= '0;
    end else begin
      if (issue_hs) begin
        rr_ptr_q <= (32'(grant_idx) == NumReq - 1) ? '0 : grant_idx + IdxWidth'(1);
        locked_q <= 1'b0;
      end else if (unit_valid_o) begin
        locked_q   <= 1'b1;
        lock_idx_q <= grant_idx;
      end
      if (issue_hs && !rsp_hs) begin
        count_q <= count_q + CntWidth'(1);
      end else if (rsp_hs && !issue_hs && count_q != '0) begin
        count_q <= count_q - CntWidth'(1);
      end
    end
  end

endmodule

// File: tb/tb_fpnew_req_sharer.sv
// Scoreboard bench for fpnew_req_sharer: directed vectors push expected issues and
// responses, a negedge monitor pops and compares them as handshakes appear.
module tb_fpnew_req_sharer;

  logic                  clk_i = 1'b0;
  logic                  rst_ni = 1'b0;
  logic                  flush_i = 1'b0;
  logic [3:0]            req_valid_i = '0;
  logic [3:0]            req_ready_o;
  logic [3:0][127:0]     req_data_i;
  logic                  unit_valid_o;
  logic                  unit_ready_i = 1'b0;
  logic [127:0]          unit_data_o;
  logic [1:0]            unit_id_o;
  logic                  unit_out_valid_i = 1'b0;
  logic                  unit_out_ready_o;
  logic [37:0]           unit_result_i = '0;
  logic [1:0]            unit_id_i = '0;
  logic [3:0]            rsp_valid_o;
  logic [3:0]            rsp_ready_i = '0;
  logic [37:0]           rsp_data_o;
  logic                  busy_o;

  typedef struct packed { logic [1:0] id; logic [127:0] data; } issue_t;
  typedef struct packed { logic [3:0] valid; logic [37:0] data; } rsp_t;
  issue_t exp_issue[$];
  rsp_t   exp_rsp[$];
  int vectors = 0;
  int miscompares = 0;

  fpnew_req_sharer #(
    .NumReq(4), .PayloadWidth(128), .ResultWidth(38), .MaxOutstanding(4)
  ) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .flush_i(flush_i),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_data_i(req_data_i),
    .unit_valid_o(unit_valid_o), .unit_ready_i(unit_ready_i),
    .unit_data_o(unit_data_o), .unit_id_o(unit_id_o),
    .unit_out_valid_i(unit_out_valid_i), .unit_out_ready_o(unit_out_ready_o),
    .unit_result_i(unit_result_i), .unit_id_i(unit_id_i),
    .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i),
    .rsp_data_o(rsp_data_o), .busy_o(busy_o)
  );

  always #5 clk_i = ~clk_i;

  function automatic logic [127:0] payload(input int i);
    return {96'h0, 32'hC0DE_0000 + 32'(i)};
  endfunction

  function automatic logic [37:0] result(input int i);
    return 38'h15_5000_0000 + 38'(i);
  endfunction

  initial begin
    for (int i = 0; i < 4; i++) req_data_i[i] = payload(i);
  end

  task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic [3:0] valid, input logic ready, input logic flush,
                               input logic ovalid, input logic [1:0] oid, input logic [3:0] rready);
    @(posedge clk_i);
    #1;
    req_valid_i      = valid;
    unit_ready_i     = ready;
    flush_i          = flush;
    unit_out_valid_i = ovalid;
    unit_id_i        = oid;
    unit_result_i    = result(int'(oid));
    rsp_ready_i      = rready;
  endtask

  task automatic expectIssue(input int id);
    exp_issue.push_back('{id: 2'(id), data: payload(id)});
  endtask

  task automatic expectRsp(input int id);
    exp_rsp.push_back('{valid: 4'b0001 << id, data: result(id)});
  endtask

  // Monitor: every observed handshake consumes the oldest expected entry.
  initial begin
    issue_t ei;
    rsp_t   er;
    forever begin
      @(negedge clk_i);
      if (unit_valid_o && unit_ready_i) begin
        if (exp_issue.size() == 0) begin
          vectors++;
          miscompares++;
          $display("[TB] FAIL unexpected_issue: got id %0d, expected no issue", unit_id_o);
        end else begin
          ei = exp_issue.pop_front();
          checkOutput("issue_id", 128'(unit_id_o), 128'(ei.id));
          checkOutput("issue_data", unit_data_o, ei.data);
          checkOutput("issue_ready", 128'(req_ready_o), 128'(4'b0001 << ei.id));
        end
      end
      if (unit_out_valid_i && unit_out_ready_o && (|rsp_valid_o)) begin
        if (exp_rsp.size() == 0) begin
          vectors++;
          miscompares++;
          $display("[TB] FAIL unexpected_rsp: got valid %b, expected no response", rsp_valid_o);
        end else begin
          er = exp_rsp.pop_front();
          checkOutput("rsp_valid", 128'(rsp_valid_o), 128'(er.valid));
          checkOutput("rsp_data", 128'(rsp_data_o), 128'(er.data));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    // Reset state, including a requester holding valid during reset.
    @(negedge clk_i);
    checkOutput("rst_unit_valid", 128'(unit_valid_o), 128'(0));
    checkOutput("rst_req_ready", 128'(req_ready_o), 128'(0));
    checkOutput("rst_rsp_valid", 128'(rsp_valid_o), 128'(0));
    checkOutput("rst_busy", 128'(busy_o), 128'(0));
    req_valid_i = 4'b0101;
    #1;
    checkOutput("rst_valid_gated", 128'(unit_valid_o), 128'(0));
    req_valid_i = 4'b0000;
    @(posedge clk_i);
    #1;
    rst_ni = 1'b1;

    // Round robin from 0: issues 0 then 2, pointer lands on 3.
    applyStimulus(4'b0101, 1'b1, 1'b0, 1'b0, 2'd0, 4'b0000); expectIssue(0);
    applyStimulus(4'b0101, 1'b1, 1'b0, 1'b0, 2'd0, 4'b0000); expectIssue(2);
    applyStimulus(4'b1001, 1'b0, 1'b0, 1'b0, 2'd0, 4'b0000);
    @(negedge clk_i);
    checkOutput("rr_valid", 128'(unit_valid_o), 128'(1));
    checkOutput("rr_ptr3_id", 128'(unit_id_o), 128'(3));
    applyStimulus(4'b0000, 1'b0, 1'b1, 1'b0, 2'd0, 4'b0000);
    @(negedge clk_i);
    checkOutput("flush_valid", 128'(unit_valid_o), 128'(0));
    applyStimulus(4'b0000, 1'b0, 1'b0, 1'b0, 2'd0, 4'b0000);
    @(negedge clk_i);
    checkOutput("flush_busy", 128'(busy_o), 128'(0));

    // Grant lock: requester 1 holds the grant while 0 arrives behind the pointer.
    applyStimulus(4'b0010, 1'b0, 1'b0, 1'b0, 2'd0, 4'b0000);
    @(negedge clk_i);
    checkOutput("lock_id_c1", 128'(unit_id_o), 128'(1));
    for (int c = 2; c <= 3; c++) begin
      applyStimulus(4'b0011, 1'b0, 1'b0, 1'b0, 2'd0, 4'b0000);
      @(negedge clk_i);
      checkOutput($sformatf("lock_id_c%0d", c), 128'(unit_id_o), 128'(1));
      checkOutput($sformatf("lock_ready_c%0d", c), 128'(req_ready_o), 128'(0));
    end
    applyStimulus(4'b0011, 1'b1, 1'b0, 1'b0, 2'd0, 4'b0000); expectIssue(1);
    applyStimulus(4'b0001, 1'b1, 1'b0, 1'b0, 2'd0, 4'b0000); expectIssue(0);
    applyStimulus(4'b0000, 1'b1, 1'b0, 1'b0, 2'd0, 4'b0000);

    // Outstanding limit: fill to 4, then only a same-cycle response lets one in.
    applyStimulus(4'b0100, 1'b1, 1'b0, 1'b0, 2'd0, 4'b0000); expectIssue(2);
    applyStimulus(4'b1000, 1'b1, 1'b0, 1'b0, 2'd0, 4'b0000); expectIssue(3);
    applyStimulus(4'b0010, 1'b1, 1'b0, 1'b0, 2'd0, 4'b0000);
    @(negedge clk_i);
    checkOutput("full_valid", 128'(unit_valid_o), 128'(0));
    checkOutput("full_ready", 128'(req_ready_o), 128'(0));
    checkOutput("full_busy", 128'(busy_o), 128'(1));
    applyStimulus(4'b0010, 1'b1, 1'b0, 1'b1, 2'd0, 4'b0001); expectRsp(0); expectIssue(1);
    applyStimulus(4'b0001, 1'b1, 1'b0, 1'b0, 2'd0, 4'b0000);
    @(negedge clk_i);
    checkOutput("still_full_valid", 128'(unit_valid_o), 128'(0));

    // Response to requester 3 not ready: routed but stalled, count unchanged.
    applyStimulus(4'b0001, 1'b1, 1'b0, 1'b1, 2'd3, 4'b0111);
    @(negedge clk_i);
    checkOutput("stall_rsp_valid", 128'(rsp_valid_o), 128'(4'b1000));
    checkOutput("stall_out_ready", 128'(unit_out_ready_o), 128'(0));
    checkOutput("stall_unit_valid", 128'(unit_valid_o), 128'(0));
    checkOutput("stall_rsp_data", 128'(rsp_data_o), 128'(result(3)));
    applyStimulus(4'b0001, 1'b1, 1'b0, 1'b1, 2'd2, 4'b1111); expectRsp(2); expectIssue(0);

    // Count 3 with an active lock, then flush clears both.
    applyStimulus(4'b0000, 1'b0, 1'b0, 1'b1, 2'd1, 4'b1111); expectRsp(1);
    applyStimulus(4'b0100, 1'b0, 1'b0, 1'b0, 2'd0, 4'b0000);
    @(negedge clk_i);
    checkOutput("cnt3_valid", 128'(unit_valid_o), 128'(1));
    checkOutput("cnt3_id", 128'(unit_id_o), 128'(2));
    applyStimulus(4'b0100, 1'b1, 1'b1, 1'b1, 2'd2, 4'b1111);
    @(negedge clk_i);
    checkOutput("flush2_valid", 128'(unit_valid_o), 128'(0));
    checkOutput("flush2_ready", 128'(req_ready_o), 128'(0));
    checkOutput("flush2_rsp_valid", 128'(rsp_valid_o), 128'(0));
    applyStimulus(4'b0000, 1'b0, 1'b0, 1'b0, 2'd0, 4'b0000);
    @(negedge clk_i);
    checkOutput("flush2_busy", 128'(busy_o), 128'(0));

    // After the flush four issues fit again, pointer kept at 1.
    applyStimulus(4'b1111, 1'b1, 1'b0, 1'b0, 2'd0, 4'b0000); expectIssue(1);
    applyStimulus(4'b1111, 1'b1, 1'b0, 1'b0, 2'd0, 4'b0000); expectIssue(2);
    applyStimulus(4'b1111, 1'b1, 1'b0, 1'b0, 2'd0, 4'b0000); expectIssue(3);
    applyStimulus(4'b1111, 1'b1, 1'b0, 1'b0, 2'd0, 4'b0000); expectIssue(0);
    applyStimulus(4'b1111, 1'b1, 1'b0, 1'b0, 2'd0, 4'b0000);
    @(negedge clk_i);
    checkOutput("refill_full_valid", 128'(unit_valid_o), 128'(0));

    // Asynchronous reset in the middle of a locked transfer.
    applyStimulus(4'b0000, 1'b0, 1'b1, 1'b0, 2'd0, 4'b0000);
    applyStimulus(4'b0010, 1'b0, 1'b0, 1'b0, 2'd0, 4'b0000);
    @(negedge clk_i);
    checkOutput("pre_rst_id", 128'(unit_id_o), 128'(1));
    @(posedge clk_i);
    #3;
    rst_ni = 1'b0;
    #1;
    checkOutput("async_rst_valid", 128'(unit_valid_o), 128'(0));
    req_valid_i = 4'b0000;
    #1;
    checkOutput("async_rst_busy", 128'(busy_o), 128'(0));
    @(posedge clk_i);
    #1;
    rst_ni = 1'b1;
    applyStimulus(4'b0011, 1'b1, 1'b0, 1'b0, 2'd0, 4'b0000); expectIssue(0);
    applyStimulus(4'b0000, 1'b0, 1'b0, 1'b0, 2'd0, 4'b0000);
    applyStimulus(4'b0000, 1'b0, 1'b0, 1'b0, 2'd0, 4'b0000);
    @(negedge clk_i);

    checkOutput("issue_queue_drained", 128'(exp_issue.size()), 128'(0));
    checkOutput("rsp_queue_drained", 128'(exp_rsp.size()), 128'(0));
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/fpnew_req_sharer.md
FPNEW_REQ_SHARER -- requirements
Module: fpnew_req_sharer

Interface
REQ-001 SHALL have parameter NumReq, default 4, meaning number of requesters sharing one operation-group unit (legal range 2..16).
REQ-002 SHALL have parameter PayloadWidth, default 128, meaning request payload bits (operands, op, formats, user tag).
REQ-003 SHALL have parameter ResultWidth, default 38, meaning response payload bits (result, status, extension bit, user tag).
REQ-004 SHALL have parameter MaxOutstanding, default 4, meaning maximum operations in flight inside the unit (legal 1..255).
REQ-005 SHALL derive local IdxWidth = max(1, clog2(NumReq)) and CntWidth = clog2(MaxOutstanding+1).
REQ-006 SHALL have port clk_i, input, 1, sole clock, rising edge.
REQ-007 SHALL have port rst_ni, input, 1, reset, asynchronous and active-low.
REQ-008 SHALL have port flush_i, input, 1, synchronous flush.
REQ-009 SHALL have port req_valid_i, input, NumReq, per-requester request valid.
REQ-010 SHALL have port req_ready_o, output, NumReq, per-requester request ready.
REQ-011 SHALL have port req_data_i, input, NumReq x PayloadWidth, per-requester payload.
REQ-012 SHALL have port unit_valid_o / unit_ready_i, output/input, 1 each, issue handshake to the unit.
REQ-013 SHALL have port unit_data_o, output, PayloadWidth, granted payload.
REQ-014 SHALL have port unit_id_o, output, IdxWidth, granted requester index, carried by the unit as tag.
REQ-015 SHALL have port unit_out_valid_i / unit_out_ready_o, input/output, 1 each, unit result handshake.
REQ-016 SHALL have ports unit_result_i (ResultWidth) and unit_id_i (IdxWidth), inputs, returned result and tag.
REQ-017 SHALL have port rsp_valid_o, output, NumReq, per-requester response valid.
REQ-018 SHALL have port rsp_ready_i, input, NumReq, per-requester response ready.
REQ-019 SHALL have port rsp_data_o, output, ResultWidth, unit_result_i broadcast to all requesters.
REQ-020 SHALL have port busy_o, output, 1, high while any operation is pending or in flight.

Function
REQ-021 SHALL arbitrate round-robin: search starts at rr_ptr, first requester with req_valid_i high wins.
REQ-022 SHALL advance rr_ptr to (winner+1) mod NumReq only on an issue handshake (unit_valid_o & unit_ready_i).
REQ-023 SHALL lock the grant when unit_valid_o is high and unit_ready_i low; while locked, unit_data_o/unit_id_o stay on the locked index regardless of other requesters.
REQ-024 SHALL release the lock on issue handshake or flush.
REQ-025 SHALL drive unit_valid_o = (any req_valid_i or locked) & issue_ok; req_ready_o[i] = unit_ready_i & issue_ok & (i == granted index).
REQ-026 SHALL compute issue_ok = (count < MaxOutstanding) | response handshake in the same cycle.
REQ-027 SHALL update count: +1 on issue only, -1 on response only, unchanged on both or neither; never exceeds MaxOutstanding, never underflows.
REQ-028 SHALL drive rsp_valid_o[i] = unit_out_valid_i & (unit_id_i == i); unit_out_ready_o = rsp_ready_i[unit_id_i]; zero-latency combinational path.
REQ-029 SHALL treat unit_id_i >= NumReq as error: rsp_valid_o all low, unit_out_ready_o high (result dropped), count decremented.
REQ-030 SHALL keep results out of order across requesters; ordering per requester is the unit's responsibility.
REQ-031 SHALL on flush_i: count <= 0, lock cleared, rr_ptr kept; unit_valid_o, req_ready_o, rsp_valid_o forced low that cycle.
REQ-032 SHALL drive busy_o = (count != 0) | (|req_valid_i) | locked.
REQ-033 SHALL add no latency on issue path: 0-cycle from req_valid_i to unit_valid_o.

Reset
REQ-034 SHALL on rst_ni low: rr_ptr = 0, count = 0, lock = 0, locked index = 0; all valid/ready outputs 0 while req_valid_i is 0.

Verification
REQ-035 Requests 0 and 2 valid, unit_ready_i=1, after reset -> issues 0 then 2, unit_id_o 0 then 2, rr_ptr ends at 3.
REQ-036 Req 1 valid, unit_ready_i=0 for 3 cycles, req 0 raised cycle 2 -> unit_id_o stays 1 all 3 cycles; req 1 issued when unit_ready_i=1.
REQ-037 MaxOutstanding=4, 4 issues, no responses -> 5th request sees unit_valid_o=0; response with same-cycle 5th request -> issue accepted, count stays 4.
REQ-038 unit_out_valid_i=1, unit_id_i=3, rsp_ready_i[3]=0 -> rsp_valid_o=4'b1000, unit_out_ready_o=0, count unchanged.
REQ-039 count=3, lock active, flush_i pulsed -> count=0, lock cleared, busy_o low next cycle with no requests.
REQ-040 rst_ni asserted mid-locked-transfer -> all state zero immediately, unit_valid_o low asynchronously.
